// File: rtl/bram_word_adapter.sv
// Byte/halfword/word to byte-wide BRAM adapter: one BRAM byte access per cycle, little-endian, zero-extended reads.
// Optional BRAM_ADAPTER_ALIGN_CHECK_EN: misaligned halfword/word requests get an immediate error response instead.
module bram_word_adapter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [7:0]            bram_din,
   output logic                  bram_wen,
   output logic                  bram_ren,
   input  logic [7:0]            bram_dout
);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
   logic [31:0]           r_wdata, w_wdata_nxt;
   logic [2:0]            r_len, w_len_nxt;
   logic [2:0]            r_cyc, w_cyc_nxt;
   logic [31:0]           r_lanes, w_lanes_nxt;
   logic [ADDR_WIDTH-1:0] r_bram_addr, w_addr_nxt;
   logic [7:0]            r_bram_din, w_din_nxt;
   logic                  r_bram_wen, w_wen_nxt;
   logic                  r_bram_ren, w_ren_nxt;
   logic                  r_resp_valid, w_resp_valid_nxt;
   logic [31:0]           r_resp_rdata, w_resp_rdata_nxt;
   logic                  r_resp_err, w_resp_err_nxt;

   logic [2:0]            w_req_len;
   logic                  w_misalign;
   logic [2:0]            w_cyc_p1;
   logic                  w_issue_more;
   logic [7:0]            w_wbyte;
   logic [1:0]            w_lane_idx;
   logic [31:0]           w_dout_lane;

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign bram_addr  = r_bram_addr;
   assign bram_din   = r_bram_din;
   assign bram_wen   = r_bram_wen;
   assign bram_ren   = r_bram_ren;

   assign w_req_len = (req_size == 2'd0) ? 3'd1 : (req_size == 2'd1) ? 3'd2 : 3'd4;

`ifdef BRAM_ADAPTER_ALIGN_CHECK_EN
   assign w_misalign = ((req_size == 2'd1) & req_addr[0]) |
                       (req_size[1] & (req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_cyc_p1     = r_cyc + 3'd1;
   assign w_issue_more = (w_cyc_p1 < r_len);

   // Read data trails the issued address by one cycle, so lane r_cyc-1 is on bram_dout now.
   assign w_lane_idx  = r_cyc[1:0] - 2'd1;
   assign w_dout_lane = {24'd0, bram_dout} << {w_lane_idx, 3'b000};

   always_comb begin
      w_wbyte = r_wdata[7:0];
      case (w_cyc_p1[1:0])
         2'd0:    w_wbyte = r_wdata[7:0];
         2'd1:    w_wbyte = r_wdata[15:8];
         2'd2:    w_wbyte = r_wdata[23:16];
         default: w_wbyte = r_wdata[31:24];
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_base_nxt       = r_base;
      w_wdata_nxt      = r_wdata;
      w_len_nxt        = r_len;
      w_cyc_nxt        = r_cyc;
      w_lanes_nxt      = r_lanes;
      w_addr_nxt       = r_bram_addr;
      w_din_nxt        = r_bram_din;
      w_wen_nxt        = 1'b0;
      w_ren_nxt        = 1'b0;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_err_nxt   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_base_nxt  = req_addr;
               w_wdata_nxt = req_wdata;
               w_len_nxt   = w_req_len;
               w_cyc_nxt   = 3'd0;
               w_lanes_nxt = 32'd0;
               if (w_misalign) begin
                  w_resp_valid_nxt = 1'b1;
                  w_resp_err_nxt   = 1'b1;
               end else if (req_write) begin
                  w_state_nxt = S_WR;
                  w_addr_nxt  = req_addr;
                  w_din_nxt   = req_wdata[7:0];
                  w_wen_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_RD;
                  w_addr_nxt  = req_addr;
                  w_ren_nxt   = 1'b1;
               end
            end
         end
         S_WR: begin
            w_cyc_nxt = w_cyc_p1;
            if (w_issue_more) begin
               w_addr_nxt = r_base + ADDR_WIDTH'(w_cyc_p1);
               w_din_nxt  = w_wbyte;
               w_wen_nxt  = 1'b1;
            end else begin
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = S_IDLE;
            end
         end
         S_RD: begin
            w_cyc_nxt = w_cyc_p1;
            if (w_issue_more) begin
               w_addr_nxt = r_base + ADDR_WIDTH'(w_cyc_p1);
               w_ren_nxt  = 1'b1;
            end
            if (r_cyc != 3'd0) begin
               w_lanes_nxt = r_lanes | w_dout_lane;
            end
            // Last byte goes straight into the response; untouched upper lanes stay zero.
            if (r_cyc == r_len) begin
               w_resp_valid_nxt = 1'b1;
               w_resp_rdata_nxt = r_lanes | w_dout_lane;
               w_state_nxt      = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_base       <= '0;
         r_wdata      <= 32'd0;
         r_len        <= 3'd0;
         r_cyc        <= 3'd0;
         r_lanes      <= 32'd0;
         r_bram_addr  <= '0;
         r_bram_din   <= 8'd0;
         r_bram_wen   <= 1'b0;
         r_bram_ren   <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_base       <= w_base_nxt;
         r_wdata      <= w_wdata_nxt;
         r_len        <= w_len_nxt;
         r_cyc        <= w_cyc_nxt;
         r_lanes      <= w_lanes_nxt;
         r_bram_addr  <= w_addr_nxt;
         r_bram_din   <= w_din_nxt;
         r_bram_wen   <= w_wen_nxt;
         r_bram_ren   <= w_ren_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
      end
   end

endmodule
